// File: rtl/uart_phy_if.sv
// uart_phy_if: byte-strobe bundle between the UART controller and uart_phy.
//
// Signals:
//   tx_data  [7:0]  byte to transmit, sampled when tx_wr is accepted
//   tx_wr           write strobe, accepted only while tx_busy = 0
//   tx_busy         transmitter occupied
//   rx_data  [7:0]  last good received byte, held until the next good frame
//   rx_valid        one-cycle pulse, rx_data freshly updated
//   rx_ferr         one-cycle pulse, framing/parity error, byte dropped
//
// Modports:
//   master  controller side (drives tx_data/tx_wr)
//   slave   PHY side (drives tx_busy and the rx_* outputs)
interface uart_phy_if;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    modport master (
        output tx_data, tx_wr,
        input  tx_busy, rx_data, rx_valid, rx_ferr
    );

    modport slave (
        input  tx_data, tx_wr,
        output tx_busy, rx_data, rx_valid, rx_ferr
    );
endinterface

// File: rtl/uart_phy.sv
// uart_phy: full-duplex UART transceiver, 8 data bits, LSB first, 1 stop bit.
// Bit time is a fixed CLK_DIV clock cycles. TX and RX run independently.
//
// Optional feature: define UART_PARITY_EN to insert/check an even parity
// bit between the last data bit and the stop bit (11-bit frames). Without
// it the frame is plain 8N1 (10 bits) and no parity logic is built.
//
// Parameters:
//   CLK_DIV  clk cycles per bit (>= 4)
// Ports:
//   clk      clock
//   rst      synchronous reset, active-low
//   rxd      asynchronous serial input, idle high
//   txd      registered serial output, idle high
//   bus      uart_phy_if.slave: tx_data/tx_wr/tx_busy, rx_data/rx_valid/rx_ferr
module uart_phy #(
    parameter int CLK_DIV = 434
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    output logic      txd,
    uart_phy_if.slave bus
);

    // Counters only ever hold 0 .. CLK_DIV-1.
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
    logic [2:0]       tx_idx_q,   tx_idx_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q,      txd_d;
    logic             tx_busy_q,  tx_busy_d;
`ifdef UART_PARITY_EN
    logic             tx_par_q,   tx_par_d;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_busy_d  = tx_busy_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tx_state_q == TX_IDLE) begin
            // tx_busy is low exactly when idle, so a strobe here is accepted.
            if (bus.tx_wr) begin
                tx_state_d = TX_START;
                tx_cnt_d   = DIV_M1;
                tx_idx_d   = 3'd0;
                tx_shift_d = bus.tx_data;
                txd_d      = 1'b0;
                tx_busy_d  = 1'b1;
`ifdef UART_PARITY_EN
                tx_par_d   = ^bus.tx_data;
`endif
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
            // Bit boundary: load the next bit and restart the bit timer.
            tx_cnt_d = DIV_M1;
            case (tx_state_q)
                TX_START: begin
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shift_q[0];
                end
                TX_DATA: begin
                    tx_idx_d   = tx_idx_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        txd_d      = tx_par_q;
`else
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
`endif
                    end else begin
                        txd_d = tx_shift_q[1];
                    end
                end
                TX_PARITY: begin
                    tx_state_d = TX_STOP;
                    txd_d      = 1'b1;
                end
                TX_STOP: begin
                    tx_state_d = TX_IDLE;
                    txd_d      = 1'b1;
                    tx_busy_d  = 1'b0;
                end
                default: begin
                    tx_state_d = TX_IDLE;
                    txd_d      = 1'b1;
                    tx_busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_busy_q  <= tx_busy_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign txd         = txd_q;
    assign bus.tx_busy = tx_busy_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    logic             rx_s1_q, rx_s2_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]       rx_idx_q,   rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ferr_q,  rx_ferr_d;
    logic             rx_perr;
`ifdef UART_PARITY_EN
    logic             rx_perr_q,  rx_perr_d;
    assign rx_perr = rx_perr_q;
`else
    assign rx_perr = 1'b0;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_d  = rx_perr_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                // Half a bit to the middle of the start bit.
                if (!rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_M1;
                end
            end
            RX_START: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end else if (rx_s2_q) begin
                    rx_state_d = RX_IDLE;   // too short to be a start bit
                end else begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = DIV_M1;
                    rx_idx_d   = 3'd0;
`ifdef UART_PARITY_EN
                    rx_perr_d  = 1'b0;
`endif
                end
            end
            RX_DATA: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end else begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = DIV_M1;
                    rx_idx_d   = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end else begin
`ifdef UART_PARITY_EN
                    rx_perr_d  = rx_s2_q ^ (^rx_shift_q);
`endif
                    rx_state_d = RX_STOP;
                    rx_cnt_d   = DIV_M1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end else if (rx_s2_q) begin
                    rx_state_d = RX_IDLE;
                    if (rx_perr) begin
                        rx_ferr_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                    end
                end else begin
                    // Bad stop bit: report once, then wait out any break.
                    rx_ferr_d  = 1'b1;
                    rx_state_d = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s2_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_ferr  = rx_ferr_q;

endmodule

// File: tb/tb_uart_phy.sv
// tb_uart_phy: scoreboard bench for uart_phy at CLK_DIV = 16.
// Stimulus pushes expected TX frames / RX pulses into queues; independent
// monitors decode txd and watch rx_valid/rx_ferr and compare.
`timescale 1ns/1ps
module tb_uart_phy;
    localparam int D = 16;
`ifdef UART_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    // Edges from first low raw rxd sample to the rx pulse.
    localparam int RX_LAT = ((2 * F - 1) * D) / 2 + 2;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         at;
    } rx_exp_t;

    typedef struct {
        logic [7:0] data;
        int         at;
    } tx_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd_drv = 1'b1;
    logic loop_en = 1'b0;
    logic txd;
    logic dut_rxd;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   pulses = 0;
    int   tx_free = 0;
    logic [7:0] last_good = 8'h00;

    rx_exp_t rx_q[$];
    tx_exp_t tx_q[$];

    uart_phy_if bus();

    assign dut_rxd = loop_en ? txd : rxd_drv;

    uart_phy #(.CLK_DIV(D)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (dut_rxd),
        .txd (txd),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Line-level frame: bit 0 = start, then data LSB first, [parity], stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b, input bit stop, input bit bad_par);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
`ifdef UART_PARITY_EN
        f[9]  = (^b) ^ bad_par;
        f[10] = stop;
`else
        f[9]  = stop;
`endif
        return f;
    endfunction

    // ---------------- RX monitor ----------------
    rx_exp_t rx_e;
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1 || bus.rx_ferr === 1'b1) begin
            pulses++;
            check("rx_excl", 32'({bus.rx_valid, bus.rx_ferr} == 2'b11), 32'd0);
            if (rx_q.size() == 0) begin
                n_checks++;
                $display("FAIL rx_unexpected: valid=%b ferr=%b data=0x%h at cycle %0d, expected no pulse",
                         bus.rx_valid, bus.rx_ferr, bus.rx_data, cyc);
            end else begin
                rx_e = rx_q.pop_front();
                check("rx_kind_ferr", 32'(bus.rx_ferr), 32'(rx_e.ferr));
                check("rx_data", 32'(bus.rx_data), 32'(rx_e.data));
                n_checks++;
                if (cyc >= rx_e.at - 1 && cyc <= rx_e.at + 1) n_pass++;
                else $display("FAIL rx_time: pulse at cycle %0d, expected %0d +/-1", cyc, rx_e.at);
            end
        end
    end

    // ---------------- TX monitor ----------------
    tx_exp_t     tx_e;
    int          tx_n0;
    logic [10:0] tx_bits;
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && txd === 1'b0) begin
                tx_n0 = cyc;
                if (tx_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: frame start at cycle %0d, expected idle line", cyc);
                    repeat (F * D) @(negedge clk);
                end else begin
                    tx_e = tx_q.pop_front();
                    tx_bits = frame_of(tx_e.data, 1'b1, 1'b0);
                    check("tx_start_cyc", 32'(tx_n0), 32'(tx_e.at));
                    check("tx_busy_start", 32'(bus.tx_busy), 32'd1);
                    repeat (D / 2) @(negedge clk);
                    for (int b = 0; b < F; b++) begin
                        check($sformatf("tx_bit%0d_byte%02h", b, tx_e.data), 32'(txd), 32'(tx_bits[b]));
                        if (b < F - 1) repeat (D) @(negedge clk);
                    end
                    repeat (D / 2 - 1) @(negedge clk);
                    check("tx_busy_last", 32'(bus.tx_busy), 32'd1);
                    @(negedge clk);
                    check("tx_busy_fall", 32'(bus.tx_busy), 32'd0);
                    check("tx_idle_line", 32'(txd), 32'd1);
                end
            end
        end
    end

    // ---------------- stimulus helpers (call at a negedge) ----------------
    task automatic tx_send(input logic [7:0] b);
        int n;
        bus.tx_data = b;
        bus.tx_wr   = 1'b1;
        n = cyc + 1;
        if (n >= tx_free) begin
            tx_q.push_back('{data: b, at: n});
            tx_free = n + F * D + 1;
            if (loop_en) begin
                rx_q.push_back('{ferr: 1'b0, data: b, at: n + 1 + RX_LAT});
                last_good = b;
            end
        end
        @(negedge clk);
        bus.tx_wr   = 1'b0;
        bus.tx_data = ~b;
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop, input bit bad_par);
        logic [10:0] f;
        int e0;
        f  = frame_of(b, stop, bad_par);
        e0 = cyc + 1;
        if (stop && !bad_par) begin
            rx_q.push_back('{ferr: 1'b0, data: b, at: e0 + RX_LAT});
            last_good = b;
        end else begin
            rx_q.push_back('{ferr: 1'b1, data: last_good, at: e0 + RX_LAT});
        end
        for (int i = 0; i < F; i++) begin
            rxd_drv = f[i];
            repeat (D) @(negedge clk);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic wait_tx_idle();
        int k;
        k = 0;
        while (bus.tx_busy !== 1'b0 && k < F * D + 20) begin
            @(negedge clk);
            k++;
        end
        check("tx_idle_timeout", 32'(bus.tx_busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] rb;
        bit         st;
        bus.tx_data = 8'h00;
        bus.tx_wr   = 1'b0;

        // Reset held 3 cycles while rxd toggles.
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            rxd_drv = ~rxd_drv;
        end
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_ferr", 32'(bus.rx_ferr), 32'd0);
        rxd_drv = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_no_pulses", 32'(pulses), 32'd0);

        // TX 0xA5 with a collision (0xFF) 50 cycles into the frame.
        tx_send(8'hA5);
        repeat (48) @(negedge clk);
        check("collision_busy", 32'(bus.tx_busy), 32'd1);
        tx_send(8'hFF);
        wait_tx_idle();
        repeat (4) @(negedge clk);
        check("collision_one_frame", 32'(tx_q.size()), 32'd0);

        // Back-to-back: second write on the first cycle busy is low.
        tx_send(8'h00);
        wait_tx_idle();
        tx_send(8'hFF);
        wait_tx_idle();
        repeat (4) @(negedge clk);

        // Loopback: 0x3C, then random bytes.
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        tx_send(8'h3C);
        wait_tx_idle();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            tx_send(8'($urandom_range(0, 255)));
            wait_tx_idle();
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        repeat (D) @(negedge clk);
        loop_en = 1'b0;
        repeat (4) @(negedge clk);

        // Framing error with break, then a good 0x81.
        rx_frame(8'h55, 1'b0, 1'b0);
        rxd_drv = 1'b0;
        repeat (40) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (8) @(negedge clk);
        rx_frame(8'h81, 1'b1, 1'b0);
        repeat (D) @(negedge clk);

        // Glitch of 4 cycles, frame 20 cycles later.
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (20) @(negedge clk);
        rx_frame(8'hC3, 1'b1, 1'b0);
        repeat (D) @(negedge clk);

`ifdef UART_PARITY_EN
        rx_frame(8'h5A, 1'b1, 1'b1);
        repeat (D) @(negedge clk);
        rx_frame(8'h5B, 1'b1, 1'b0);
        repeat (D) @(negedge clk);
`endif

        // Random RX frames with concurrent TX traffic.
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) != 0);
            tx_send(8'($urandom_range(0, 255)));
            rx_frame(rb, st, 1'b0);
            if (!st) begin
                rxd_drv = 1'b0;
                repeat ($urandom_range(0, 30)) @(negedge clk);
                rxd_drv = 1'b1;
            end
            repeat ($urandom_range(4, 20)) @(negedge clk);
        end

        wait_tx_idle();
        repeat (2 * D) @(negedge clk);
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_phy.md
# uart_phy

Serial side of the SoC UART: a full-duplex 8N1 transceiver that converts the byte-wide strobe interface driven by the memory-mapped UART controller into an asynchronous TX line, and an RX line back into byte strobes. It sits between the controller's `uart_dout`/`uart_wr` and `uart_din`/`uart_valid` signals and the board pins. Baud rate is a fixed integer divider of `clk`.

## Interface

Parameters:
- `CLK_DIV`, default 434: `clk` cycles per bit (50 MHz / 115200). Must be ≥ 4.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-low.
- `rxd` in 1: asynchronous serial input, idle high.
- `txd` out 1: serial output, idle high.
- `tx_data` in 8: byte to send; sampled when `tx_wr` is accepted.
- `tx_wr` in 1: write strobe; accepted only when `tx_busy` = 0.
- `tx_busy` out 1: transmitter occupied.
- `rx_data` out 8: last received byte; held until the next good frame.
- `rx_valid` out 1: one-cycle pulse, `rx_data` valid.
- `rx_ferr` out 1: one-cycle pulse, framing (or parity) error; byte dropped.

## Operation

- Reset values: `txd`=1, `tx_busy`=0, `rx_data`=0, `rx_valid`=0, `rx_ferr`=0. RX synchroniser flops reset to 1. Reset mid-frame aborts both directions; no partial byte is reported.
- TX FSM: IDLE → START → DATA(8 bits, LSB first) → [PARITY] → STOP → IDLE. Each state holds `txd` for exactly `CLK_DIV` cycles via a down-counter; a 3-bit index counts data bits.
- `tx_wr` while `tx_busy`=1 is ignored; no queuing. `tx_data` changes after acceptance do not affect the frame in flight.
- RX: `rxd` passes through a 2-flop synchroniser. RX FSM: IDLE → START → DATA → [PARITY] → STOP → (WAIT_HIGH) → IDLE.
  - IDLE: synchronised low starts a counter of `CLK_DIV/2` (integer division).
  - START: at mid-bit, sample; if high, treat as glitch and return to IDLE with no pulse.
  - DATA: sample every `CLK_DIV` cycles, shift in LSB first.
  - STOP: sample at mid-bit. If 1 → `rx_data` updated, `rx_valid` pulses, return to IDLE. If 0 → `rx_ferr` pulses, `rx_data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: remain until synchronised `rxd` = 1, then IDLE. A break (held low) produces exactly one `rx_ferr`.
- `rx_valid` and `rx_ferr` never assert in the same cycle. No back-pressure on RX: a new pulse overwrites regardless of consumer.
- TX and RX are fully independent; simultaneous activity is legal.

## Timing

- `tx_wr` sampled high at edge N (with `tx_busy`=0): at edge N, `txd`←0 and `tx_busy`←1. Each bit lasts `CLK_DIV` cycles. `tx_busy` falls at edge N+F·`CLK_DIV`, where F = 10 (11 with parity). The earliest next accepted `tx_wr` is at edge N+F·`CLK_DIV`+1.
- `txd` is a registered output and has no combinational path from `tx_wr`.
- RX: measured from the first `clk` edge at which raw `rxd` is low, `rx_valid`/`rx_ferr` pulses at edge (F−0.5)·`CLK_DIV` + 2 ± 1.
- Tolerates ±3% baud mismatch at `CLK_DIV` ≥ 16.

## Configuration

- `UART_PARITY_EN` defined: even parity.
  - TX inserts a parity bit (XOR of the 8 data bits) between the last data bit and the stop bit.
  - RX samples the parity bit. On mismatch, RX pulses `rx_ferr` in the stop-bit cycle instead of `rx_valid`, then returns to IDLE if the stop bit is 1.
  - Frame length is 11 bits.
- Undefined: 8N1, 10-bit frames, no parity logic.

## Test plan

All scenarios use `CLK_DIV`=16.
- Reset: hold `rst`=0 for 3 cycles while `rxd` toggles → `txd`=1, `tx_busy`=0, no `rx_valid`/`rx_ferr` pulses.
- TX: `tx_wr` with `tx_data`=0xA5 → `txd` bits 0,1,0,1,0,0,1,0,1,1 (16 cycles each; with parity, 0 inserted before stop). `tx_busy` high for 160 cycles (176 with parity).
- TX collision: second `tx_wr` with 0xFF at cycle 50 of a frame → ignored; frame carries the original byte; only one frame is sent.
- Loopback: `txd`→`rxd`, send 0x3C → single `rx_valid` pulse with `rx_data`=0x3C at ~154 cycles after the start edge.
- Framing error: drive frame 0x55 with stop bit 0, then hold low 40 cycles → exactly one `rx_ferr`, `rx_data` unchanged. A following good 0x81 is received correctly.
- Glitch: `rxd` low for 4 cycles → no pulse, RX back in IDLE. A frame starting 20 cycles later is received correctly.
